// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet RX slot writer.
// Four 4 KiB slots are addressed by buffer address bits [12:11].
package eth_rx_pkg;

  localparam int NSLOT   = 4;
  localparam int SLOT_AW = 11;
  localparam int LEN_W   = 12;

  typedef logic [1:0]       slot_t;
  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } rx_state_e;

  typedef struct packed {
    logic vld;
    len_t len;
  } commit_t;

endpackage

// File: rtl/eth_rx_slot_queue.sv
// In-order completion queue of committed frame slots with per-slot length.
// A commit arrives one cycle after the frame's last byte and lands a cycle later.
module eth_rx_slot_queue
  import eth_rx_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  commit_t commit_i,
  input  logic    rel_i,
  output logic    full_o,
  output slot_t   wr_slot_o,
  output logic    frm_valid_o,
  output slot_t   frm_slot_o,
  output len_t    frm_len_o
);

  slot_t      wr_q, rd_q, wr_d, rd_d;
  logic [2:0] cnt_q, cnt_d;
  len_t       len_q [NSLOT];
  commit_t    pend_q;
  logic       rel_ok;
  logic       frm_valid_q;
  slot_t      frm_slot_q;
  len_t       frm_len_q, head_len;

  always_comb begin
    rel_ok = rel_i && (cnt_q != 3'd0);
    wr_d   = wr_q + slot_t'(pend_q.vld);
    rd_d   = rd_q + slot_t'(rel_ok);
    cnt_d  = cnt_q + 3'(pend_q.vld) - 3'(rel_ok);
    // The slot being committed becomes the head when the queue drains to it.
    head_len = (pend_q.vld && (wr_q == rd_d)) ? pend_q.len : len_q[rd_d];
  end

  // A frame starting now must see the commit still in flight.
  assign full_o    = (cnt_q + 3'(pend_q.vld)) >= 3'(NSLOT);
  assign wr_slot_o = wr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      frm_valid_q <= 1'b0;
      frm_slot_q  <= '0;
      frm_len_q   <= '0;
      for (int i = 0; i < NSLOT; i++) len_q[i] <= '0;
    end else begin
      pend_q <= commit_i;
      if (pend_q.vld) len_q[wr_q] <= pend_q.len;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      frm_valid_q <= (cnt_d != 3'd0);
      frm_slot_q  <= rd_d;
      frm_len_q   <= head_len;
    end
  end

  assign frm_valid_o = frm_valid_q;
  assign frm_slot_o  = frm_slot_q;
  assign frm_len_o   = frm_len_q;

endmodule

// File: rtl/eth_rx_slot_writer.sv
// MAC RX byte stream to RX buffer port-A writer with slot allocation and drop counting.
// Slot availability is decided once, on the first byte of each frame.
module eth_rx_slot_writer
  import eth_rx_pkg::*;
#(
  parameter int MAX_LEN = 1522
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_last_i,
  input  logic        rx_err_i,
  output logic        mem_en_o,
  output logic [1:0]  mem_we_o,
  output logic [12:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  output logic        frm_valid_o,
  output logic [1:0]  frm_slot_o,
  output logic [11:0] frm_len_o,
  input  logic        rel_i,
  output logic [15:0] drop_cnt_o
);

  rx_state_e   state_q, state_d;
  len_t        len_q, len_d;
  slot_t       slot_q, slot_d;
  logic [15:0] drop_q, drop_d;
  logic        mem_en_q, mem_en_d;
  logic [1:0]  mem_we_q, mem_we_d;
  logic [12:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;

  commit_t commit_d;
  logic    q_full;
  slot_t   q_wr_slot;
  logic    drop_evt, wr_byte;
  len_t    wr_off;
  slot_t   wr_slot;

  eth_rx_slot_queue u_queue (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .commit_i    (commit_d),
    .rel_i       (rel_i),
    .full_o      (q_full),
    .wr_slot_o   (q_wr_slot),
    .frm_valid_o (frm_valid_o),
    .frm_slot_o  (frm_slot_o),
    .frm_len_o   (frm_len_o)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    slot_d   = slot_q;
    commit_d = '0;
    drop_evt = 1'b0;
    wr_byte  = 1'b0;
    wr_off   = len_q;
    wr_slot  = slot_q;
    if (rx_valid_i) begin
      unique case (state_q)
        IDLE: begin
          if (!q_full) begin
            wr_byte = 1'b1;
            wr_off  = '0;
            wr_slot = q_wr_slot;
            slot_d  = q_wr_slot;
            len_d   = len_t'(1);
            if (rx_last_i) begin
              if (rx_err_i) drop_evt = 1'b1;
              else          commit_d = '{vld: 1'b1, len: len_t'(1)};
            end else begin
              state_d = RECV;
            end
          end else if (rx_last_i) begin
            drop_evt = 1'b1;
          end else begin
            state_d = DROP;
          end
        end
        RECV: begin
          // Oversize: the offending byte is never written.
          if (len_q >= len_t'(MAX_LEN)) begin
            if (rx_last_i) begin
              drop_evt = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = DROP;
            end
          end else begin
            wr_byte = 1'b1;
            len_d   = len_q + len_t'(1);
            if (rx_last_i) begin
              state_d = IDLE;
              if (rx_err_i) drop_evt = 1'b1;
              else          commit_d = '{vld: 1'b1, len: len_q + len_t'(1)};
            end
          end
        end
        DROP: begin
          if (rx_last_i) begin
            drop_evt = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    mem_en_d    = wr_byte;
    mem_we_d    = wr_byte ? (wr_off[0] ? 2'b10 : 2'b01) : 2'b00;
    mem_addr_d  = wr_byte ? {wr_slot, wr_off[SLOT_AW:1]} : mem_addr_q;
    mem_wdata_d = wr_byte ? {rx_data_i, rx_data_i} : mem_wdata_q;
    drop_d      = (drop_evt && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      len_q       <= '0;
      slot_q      <= '0;
      drop_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      slot_q      <= slot_d;
      drop_q      <= drop_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_eth_rx_slot_writer.sv
// Directed bench for eth_rx_slot_writer: table of per-frame vectors plus corner-case sequences.
module tb_eth_rx_slot_writer;
  import eth_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_last, rx_err, rel;
  logic        mem_en_o;
  logic [1:0]  mem_we_o;
  logic [12:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        frm_valid_o;
  logic [1:0]  frm_slot_o;
  logic [11:0] frm_len_o;
  logic [15:0] drop_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [12:0] wa [$];
  logic [1:0]  ww [$];
  logic [15:0] wd [$];

  eth_rx_slot_writer #(.MAX_LEN(1522)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_last_i   (rx_last),
    .rx_err_i    (rx_err),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .frm_valid_o (frm_valid_o),
    .frm_slot_o  (frm_slot_o),
    .frm_len_o   (frm_len_o),
    .rel_i       (rel),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_en_o) begin
      wa.push_back(mem_addr_o);
      ww.push_back(mem_we_o);
      wd.push_back(mem_wdata_o);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    int          len;
    bit          err;
    bit          rel_before;
    logic [7:0]  tag;
    logic        pre_valid;
    int          exp_nwr;
    slot_t       exp_wslot;
    logic [15:0] exp_drop;
    logic        exp_valid;
    slot_t       exp_fslot;
    logic [11:0] exp_flen;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_wr();
    wa.delete();
    ww.delete();
    wd.delete();
  endtask

  task automatic do_reset();
    rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; rel = 1'b0; rx_data = '0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    clr_wr();
  endtask

  task automatic send_frame(input int len, input bit err, input logic [7:0] tag, input bit rel_after);
    for (int i = 0; i < len; i++) begin
      rx_valid = 1'b1;
      rx_data  = tag ^ 8'(i);
      rx_last  = (i == len - 1);
      rx_err   = err && (i == len - 1);
      cyc(1);
    end
    rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
    if (rel_after) begin
      rel = 1'b1;
      cyc(1);
      rel = 1'b0;
    end
  endtask

  task automatic pulse_rel();
    rel = 1'b1;
    cyc(1);
    rel = 1'b0;
  endtask

  // Write k of a frame: halfword k>>1 in its slot, lane k[0], byte on both lanes.
  task automatic check_writes(input string nm, input int base, input int n, input slot_t slot,
                              input logic [7:0] tag);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      b = tag ^ 8'(k);
      if (base + k >= wa.size()) bad++;
      else if (wa[base+k] !== {slot, 11'(k >> 1)} || ww[base+k] !== ((k % 2) ? 2'b10 : 2'b01) ||
               wd[base+k] !== {b, b}) bad++;
    end
    chk({nm, "_content_bad"}, 32'(bad), 32'd0);
  endtask

  initial begin
    vt[0] = '{64, 1'b0, 1'b0, 8'h00, 1'b0, 64, 2'd0, 16'd0, 1'b1, 2'd0, 12'd64};
    vt[1] = '{10, 1'b1, 1'b0, 8'h11, 1'b1, 10, 2'd1, 16'd1, 1'b1, 2'd0, 12'd64};
    vt[2] = '{20, 1'b0, 1'b1, 8'h22, 1'b0, 20, 2'd1, 16'd1, 1'b1, 2'd1, 12'd20};
    vt[3] = '{1,  1'b0, 1'b0, 8'h33, 1'b1, 1,  2'd2, 16'd1, 1'b1, 2'd1, 12'd20};
    vt[4] = '{7,  1'b0, 1'b0, 8'h44, 1'b1, 7,  2'd3, 16'd1, 1'b1, 2'd1, 12'd20};
    vt[5] = '{5,  1'b0, 1'b0, 8'h55, 1'b1, 5,  2'd0, 16'd1, 1'b1, 2'd1, 12'd20};
    vt[6] = '{9,  1'b0, 1'b0, 8'h66, 1'b1, 0,  2'd0, 16'd2, 1'b1, 2'd1, 12'd20};
    vt[7] = '{3,  1'b0, 1'b1, 8'h77, 1'b1, 3,  2'd1, 16'd2, 1'b1, 2'd2, 12'd1};

    rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; rel = 1'b0; rx_data = '0;
    rst_n = 1'b0;
    cyc(2);
    chk("reset_mem", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}, 32'd0);
    chk("reset_frm", {1'b0, frm_valid_o, frm_slot_o, frm_len_o, drop_cnt_o}, 32'd0);
    rst_n = 1'b1;
    cyc(1);
    clr_wr();

    // Table: each vector is one frame, checked once the commit has landed.
    for (int v = 0; v < 8; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      if (vt[v].rel_before) pulse_rel();
      clr_wr();
      send_frame(vt[v].len, vt[v].err, vt[v].tag, 1'b0);
      chk({nm, "_valid_t1"}, 32'(frm_valid_o), 32'(vt[v].pre_valid));
      cyc(2);
      chk({nm, "_nwr"}, 32'(wa.size()), 32'(vt[v].exp_nwr));
      check_writes(nm, 0, vt[v].exp_nwr, vt[v].exp_wslot, vt[v].tag);
      chk({nm, "_drop"}, 32'(drop_cnt_o), 32'(vt[v].exp_drop));
      chk({nm, "_valid"}, 32'(frm_valid_o), 32'(vt[v].exp_valid));
      chk({nm, "_slot"}, 32'(frm_slot_o), 32'(vt[v].exp_fslot));
      chk({nm, "_len"}, 32'(frm_len_o), 32'(vt[v].exp_flen));
    end

    // Five back-to-back 60-byte frames: fifth sees the in-flight commit and drops.
    do_reset();
    for (int f = 0; f < 5; f++) send_frame(60, 1'b0, 8'(8'h10 * f + 1), 1'b0);
    cyc(2);
    chk("b2b_nwr", 32'(wa.size()), 32'd240);
    for (int f = 0; f < 4; f++)
      check_writes($sformatf("b2b_f%0d", f), f * 60, 60, slot_t'(f), 8'(8'h10 * f + 1));
    chk("b2b_drop", 32'(drop_cnt_o), 32'd1);
    chk("b2b_head", {19'd0, frm_valid_o, frm_slot_o, frm_len_o}, {19'd0, 1'b1, 2'd0, 12'd60});
    pulse_rel();
    chk("b2b_rel_slot", 32'(frm_slot_o), 32'd1);

    // Oversize frame: bytes past 1522 never written, drop counted only at last.
    do_reset();
    for (int i = 0; i < 1600; i++) begin
      if (i == 1560) begin
        chk("ovr_drop_mid", 32'(drop_cnt_o), 32'd0);
        chk("ovr_nwr_mid", 32'(wa.size()), 32'd1522);
      end
      rx_valid = 1'b1;
      rx_data  = 8'h5A ^ 8'(i);
      rx_last  = (i == 1599);
      rx_err   = 1'b0;
      cyc(1);
    end
    rx_valid = 1'b0; rx_last = 1'b0;
    chk("ovr_drop_t1", 32'(drop_cnt_o), 32'd1);
    cyc(2);
    chk("ovr_nwr", 32'(wa.size()), 32'd1522);
    check_writes("ovr", 0, 1522, 2'd0, 8'h5A);
    chk("ovr_drop", 32'(drop_cnt_o), 32'd1);
    chk("ovr_valid", 32'(frm_valid_o), 32'd0);

    // Commit and release in the same cycle at count 2, with both pointers wrapping.
    do_reset();
    send_frame(10, 1'b0, 8'hA0, 1'b0);
    send_frame(11, 1'b0, 8'hA1, 1'b0);
    send_frame(12, 1'b0, 8'hA2, 1'b0);
    send_frame(13, 1'b0, 8'hA3, 1'b0);
    cyc(2);
    repeat (3) pulse_rel();
    chk("cr_head3", {20'd0, frm_slot_o, frm_len_o}, {20'd0, 2'd3, 12'd13});
    clr_wr();
    send_frame(14, 1'b0, 8'hB0, 1'b0);
    cyc(2);
    check_writes("cr_wrwrap", 0, 14, 2'd0, 8'hB0);
    clr_wr();
    send_frame(15, 1'b0, 8'hB1, 1'b1);
    chk("cr_same_head", {19'd0, frm_valid_o, frm_slot_o, frm_len_o}, {19'd0, 1'b1, 2'd0, 12'd14});
    cyc(1);
    check_writes("cr_slot1", 0, 15, 2'd1, 8'hB1);
    pulse_rel();
    chk("cr_second", {19'd0, frm_valid_o, frm_slot_o, frm_len_o}, {19'd0, 1'b1, 2'd1, 12'd15});
    pulse_rel();
    chk("cr_empty", 32'(frm_valid_o), 32'd0);
    pulse_rel();
    clr_wr();
    send_frame(6, 1'b0, 8'hB2, 1'b0);
    cyc(2);
    check_writes("cr_after_empty_rel", 0, 6, 2'd2, 8'hB2);
    chk("cr_after_head", {19'd0, frm_valid_o, frm_slot_o, frm_len_o}, {19'd0, 1'b1, 2'd2, 12'd6});

    // Reset in the middle of a frame clears everything at once.
    do_reset();
    send_frame(5, 1'b0, 8'hC0, 1'b0);
    send_frame(4, 1'b1, 8'hC1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      rx_valid = 1'b1; rx_data = 8'hC2 ^ 8'(i); rx_last = 1'b0; rx_err = 1'b0;
      cyc(1);
    end
    rx_valid = 1'b0;
    chk("mid_pre_en", 32'(mem_en_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}, 32'd0);
    chk("mid_rst_frm", {1'b0, frm_valid_o, frm_slot_o, frm_len_o, drop_cnt_o}, 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    clr_wr();
    send_frame(25, 1'b0, 8'hD0, 1'b0);
    cyc(2);
    check_writes("mid_after", 0, 25, 2'd0, 8'hD0);
    chk("mid_after_head", {3'd0, frm_valid_o, frm_slot_o, frm_len_o, drop_cnt_o},
        {3'd0, 1'b1, 2'd0, 12'd25, 16'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
